// File: rtl/cpu_control_fsm.sv
// Multicycle control sequencer for the RV32I core: steps each instruction through
// fetch/decode/execute/mem/write-back, checks opcode legality and counts retirements.
module cpu_control_fsm #(
  parameter int unsigned IMEM_LATENCY  = 1,
  parameter int unsigned DMEM_LATENCY  = 1,
  parameter logic [31:0] INSTRET_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  output logic        imem_rd,
  output logic        ir_load,
  output logic        dmem_rd,
  output logic        dmem_wren,
  output logic        reg_wren,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        pc_wren,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    FETCH_WAIT = 3'd2,
    DECODE     = 3'd3,
    EXECUTE    = 3'd4,
    MEM        = 3'd5,
    WRITEBACK  = 3'd6,
    TRAP       = 3'd7
  } state_t;

  typedef struct packed {
    logic       imem_rd;
    logic       ir_load;
    logic       dmem_rd;
    logic       dmem_wren;
    logic       reg_wren;
    logic [1:0] wb_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       pc_wren;
    logic [1:0] pc_sel;
  } ctrl_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Wait counters count down to zero, so they start at latency-1.
  localparam logic [3:0] IMEM_WAIT = 4'(IMEM_LATENCY - 1);
  localparam logic [3:0] DMEM_WAIT = 4'(DMEM_LATENCY - 1);

  state_t     st;
  ctrl_t      ctrl;
  logic [3:0] cnt;
  logic       taken;

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_REG: is_legal = 1'b1;
      OP_JALR:   is_legal = (f3 == 3'b000);
      OP_BRANCH: is_legal = !(f3 inside {3'b010, 3'b011});
      OP_LOAD:   is_legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OP_STORE:  is_legal = f3 inside {3'b000, 3'b001, 3'b010};
      default:   is_legal = 1'b0;
    endcase
  endfunction

  function automatic ctrl_t sel_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    c.alu_a_sel = (op == OP_AUIPC);
    c.alu_b_sel = op inside {OP_IMM, OP_LOAD, OP_STORE, OP_AUIPC, OP_JALR};
    return c;
  endfunction

  function automatic ctrl_t mem_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = sel_ctrl(op);
    c.dmem_rd   = (op == OP_LOAD);
    c.dmem_wren = (op == OP_STORE);
    return c;
  endfunction

  function automatic ctrl_t wb_ctrl(input logic [6:0] op, input logic tk);
    ctrl_t c;
    c = sel_ctrl(op);
    c.pc_wren  = 1'b1;
    c.reg_wren = !(op inside {OP_STORE, OP_BRANCH});
    case (op)
      OP_LOAD:         c.wb_sel = 2'b01;
      OP_JAL, OP_JALR: c.wb_sel = 2'b10;
      OP_LUI:          c.wb_sel = 2'b11;
      default:         c.wb_sel = 2'b00;
    endcase
    case (op)
      OP_JAL:    c.pc_sel = 2'b01;
      OP_BRANCH: c.pc_sel = tk ? 2'b01 : 2'b00;
      OP_JALR:   c.pc_sel = 2'b10;
      default:   c.pc_sel = 2'b00;
    endcase
    return c;
  endfunction

  // Outputs are registered: each transition loads the control word of the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= IDLE;
      ctrl    <= '0;
      cnt     <= 4'd0;
      taken   <= 1'b0;
      illegal <= 1'b0;
      instret <= INSTRET_RESET;
    end else begin
      ctrl <= '0;
      case (st)
        IDLE: begin
          if (run) begin
            st           <= FETCH;
            ctrl.imem_rd <= 1'b1;
          end
        end
        FETCH: begin
          st           <= FETCH_WAIT;
          cnt          <= IMEM_WAIT;
          ctrl.ir_load <= (IMEM_WAIT == 4'd0);
        end
        FETCH_WAIT: begin
          if (cnt == 4'd0) begin
            st <= DECODE;
          end else begin
            cnt          <= cnt - 4'd1;
            ctrl.ir_load <= (cnt == 4'd1);
          end
        end
        DECODE: begin
          if (is_legal(opcode, funct3)) begin
            st   <= EXECUTE;
            ctrl <= sel_ctrl(opcode);
          end else begin
            st      <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXECUTE: begin
          taken <= branch_taken;
          if (opcode inside {OP_LOAD, OP_STORE}) begin
            st   <= MEM;
            cnt  <= DMEM_WAIT;
            ctrl <= mem_ctrl(opcode);
          end else begin
            st   <= WRITEBACK;
            ctrl <= wb_ctrl(opcode, branch_taken);
          end
        end
        MEM: begin
          if (opcode == OP_STORE || cnt == 4'd0) begin
            st   <= WRITEBACK;
            ctrl <= wb_ctrl(opcode, taken);
          end else begin
            cnt  <= cnt - 4'd1;
            ctrl <= sel_ctrl(opcode);
          end
        end
        WRITEBACK: begin
          instret <= instret + 32'd1;
          if (run) begin
            st           <= FETCH;
            ctrl.imem_rd <= 1'b1;
          end else begin
            st <= IDLE;
          end
        end
        TRAP:    st <= TRAP;
        default: st <= IDLE;
      endcase
    end
  end

  assign imem_rd   = ctrl.imem_rd;
  assign ir_load   = ctrl.ir_load;
  assign dmem_rd   = ctrl.dmem_rd;
  assign dmem_wren = ctrl.dmem_wren;
  assign reg_wren  = ctrl.reg_wren;
  assign wb_sel    = ctrl.wb_sel;
  assign alu_a_sel = ctrl.alu_a_sel;
  assign alu_b_sel = ctrl.alu_b_sel;
  assign pc_wren   = ctrl.pc_wren;
  assign pc_sel    = ctrl.pc_sel;
  assign state     = st;

endmodule
